// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer: registered lookup, round-robin replacement and flush.
// Optional 2-bit per-entry confidence counters when BTB_CONF_EN is defined.
module branch_target_buffer_sa #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SETS = 16,
    parameter int unsigned WAYS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            resp_valid,
    output logic            resp_hit,
    output logic [XLEN-1:0] resp_target,
    output logic            resp_taken,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            flush
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [SETS-1:0][WAYS-1:0]            valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][XLEN-1:0]  tgt_q, tgt_d;
    logic [SETS-1:0][WAY_W-1:0]           rr_q, rr_d;
`ifdef BTB_CONF_EN
    logic [SETS-1:0][WAYS-1:0][1:0]       ctr_q, ctr_d;
`endif

    logic            resp_valid_q, resp_valid_d;
    logic            resp_hit_q, resp_hit_d;
    logic [XLEN-1:0] resp_target_q, resp_target_d;
    logic            resp_taken_q, resp_taken_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit, inv_found;
    logic [WAY_W-1:0] lk_way, up_way, inv_way, alloc_way;
    logic             unused_pc_lsbs;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Descending scans so the lowest matching / invalid way is the one left selected.
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        resp_valid_d  = lookup_valid;
        resp_hit_d    = lookup_valid & lk_hit & ~flush;
        resp_target_d = resp_hit_d ? tgt_q[lk_idx][lk_way] : '0;
`ifdef BTB_CONF_EN
        resp_taken_d  = resp_hit_d & ctr_q[lk_idx][lk_way][1];
`else
        resp_taken_d  = resp_hit_d;
`endif
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        tgt_d     = tgt_q;
        rr_d      = rr_q;
`ifdef BTB_CONF_EN
        ctr_d     = ctr_q;
`endif
        alloc_way = inv_found ? inv_way : rr_q[up_idx];
        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end else if (upd_valid && upd_taken) begin
            if (up_hit) begin
                tgt_d[up_idx][up_way] = upd_target;
`ifdef BTB_CONF_EN
                if (ctr_q[up_idx][up_way] != 2'd3) begin
                    ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] + 2'd1;
                end
`endif
            end else begin
                valid_d[up_idx][alloc_way] = 1'b1;
                tag_d[up_idx][alloc_way]   = up_tag;
                tgt_d[up_idx][alloc_way]   = upd_target;
`ifdef BTB_CONF_EN
                ctr_d[up_idx][alloc_way]   = 2'b10;
`endif
                // A single-way set has nothing to rotate through.
                if (!inv_found && (WAYS > 1)) begin
                    rr_d[up_idx] = rr_q[up_idx] + 1'b1;
                end
            end
`ifdef BTB_CONF_EN
        end else if (upd_valid && up_hit) begin
            if (ctr_q[up_idx][up_way] != 2'd0) begin
                ctr_d[up_idx][up_way] = ctr_q[up_idx][up_way] - 2'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            rr_q          <= '0;
`ifdef BTB_CONF_EN
            ctr_q         <= '0;
`endif
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_target_q <= '0;
            resp_taken_q  <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rr_q          <= rr_d;
`ifdef BTB_CONF_EN
            ctr_q         <= ctr_d;
`endif
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            resp_target_q <= resp_target_d;
            resp_taken_q  <= resp_taken_d;
        end
    end

    // Tag and target storage is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign resp_target = resp_target_q;
    assign resp_taken  = resp_taken_q;

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Directed self-checking bench for branch_target_buffer_sa (SETS=16, WAYS=2).
// Define BTB_CONF_EN for both RTL and bench to exercise the confidence counters.
module tb_branch_target_buffer_sa;

    logic        clk;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_target;
    logic        resp_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush;

    int n_checks = 0;
    int n_fails  = 0;

    branch_target_buffer_sa #(
        .XLEN(32),
        .SETS(16),
        .WAYS(2)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .lookup_valid(lookup_valid),
        .lookup_pc   (lookup_pc),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_target (resp_target),
        .resp_taken  (resp_taken),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        lookup_valid = 1'b0;
        lookup_pc    = '0;
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_target   = '0;
        upd_taken    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
        step();
        clear_inputs();
    endtask

    task automatic do_lookup(input string tag, input logic [31:0] pc, input logic hit,
                             input logic [31:0] tgt, input logic taken);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        step();
        clear_inputs();
        check({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, ".hit"}, {31'd0, resp_hit}, {31'd0, hit});
        check({tag, ".target"}, resp_target, tgt);
        check({tag, ".taken"}, {31'd0, resp_taken}, {31'd0, taken});
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        // T1: reset state, then a lookup into an empty table
        do_reset();
        check("t1_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("t1_rst_hit", {31'd0, resp_hit}, 32'd0);
        check("t1_rst_target", resp_target, 32'd0);
        do_lookup("t1_lk100", 32'h100, 1'b0, 32'h0, 1'b0);
        step();
        check("t1_idle_valid", {31'd0, resp_valid}, 32'd0);

        // T2: allocate and hit; neighbour PC misses; pc[1:0] ignored
        do_reset();
        do_upd(32'h1000, 32'h2000, 1'b1);
        do_lookup("t2_hit", 32'h1000, 1'b1, 32'h2000, 1'b1);
        do_lookup("t2_miss", 32'h1004, 1'b0, 32'h0, 1'b0);
        do_lookup("t2_lsb", 32'h1002, 1'b1, 32'h2000, 1'b1);

        // T3: round-robin replacement in set 0
        do_reset();
        do_upd(32'h000, 32'hA0, 1'b1);
        do_upd(32'h040, 32'hB0, 1'b1);
        do_upd(32'h080, 32'hC0, 1'b1);
        do_lookup("t3_040", 32'h040, 1'b1, 32'hB0, 1'b1);
        do_lookup("t3_080", 32'h080, 1'b1, 32'hC0, 1'b1);
        do_lookup("t3_000", 32'h000, 1'b0, 32'h0, 1'b0);
        do_upd(32'h0C0, 32'hE0, 1'b1);
        do_lookup("t3_0c0", 32'h0C0, 1'b1, 32'hE0, 1'b1);
        do_lookup("t3_040b", 32'h040, 1'b0, 32'h0, 1'b0);
        do_lookup("t3_080b", 32'h080, 1'b1, 32'hC0, 1'b1);
        // hit update rewrites target without advancing rr (rr=0 -> way0 holds 0x080)
        do_upd(32'h080, 32'hD0, 1'b1);
        do_lookup("t3_080c", 32'h080, 1'b1, 32'hD0, 1'b1);
        do_upd(32'h100, 32'hF0, 1'b1);
        do_lookup("t3_100", 32'h100, 1'b1, 32'hF0, 1'b1);
        do_lookup("t3_080d", 32'h080, 1'b0, 32'h0, 1'b0);
        do_lookup("t3_0c0b", 32'h0C0, 1'b1, 32'hE0, 1'b1);

        // T4: read-before-write on same-cycle lookup and update
        do_reset();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h300;
        upd_valid    = 1'b1;
        upd_pc       = 32'h300;
        upd_target   = 32'h400;
        upd_taken    = 1'b1;
        step();
        clear_inputs();
        check("t4_rbw_valid", {31'd0, resp_valid}, 32'd1);
        check("t4_rbw_hit", {31'd0, resp_hit}, 32'd0);
        check("t4_rbw_target", resp_target, 32'd0);
        do_lookup("t4_after", 32'h300, 1'b1, 32'h400, 1'b1);

        // T5: flush beats a same-cycle update, clears valid and rr
        do_reset();
        do_upd(32'h800, 32'h900, 1'b1);
        do_upd(32'h840, 32'h940, 1'b1);
        do_upd(32'h880, 32'h980, 1'b1);
        do_upd(32'h804, 32'h904, 1'b1);
        do_lookup("t5_pre", 32'h804, 1'b1, 32'h904, 1'b1);
        flush        = 1'b1;
        upd_valid    = 1'b1;
        upd_pc       = 32'h500;
        upd_target   = 32'h600;
        upd_taken    = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h840;
        step();
        clear_inputs();
        check("t5_fl_valid", {31'd0, resp_valid}, 32'd1);
        check("t5_fl_hit", {31'd0, resp_hit}, 32'd0);
        do_lookup("t5_800", 32'h800, 1'b0, 32'h0, 1'b0);
        do_lookup("t5_840", 32'h840, 1'b0, 32'h0, 1'b0);
        do_lookup("t5_880", 32'h880, 1'b0, 32'h0, 1'b0);
        do_lookup("t5_804", 32'h804, 1'b0, 32'h0, 1'b0);
        do_lookup("t5_500", 32'h500, 1'b0, 32'h0, 1'b0);
        // rr of set 0 was 1 before flush; with rr cleared, 0x080 evicts way0
        do_upd(32'h000, 32'hA0, 1'b1);
        do_upd(32'h040, 32'hB0, 1'b1);
        do_upd(32'h080, 32'hC0, 1'b1);
        do_lookup("t5_rr_040", 32'h040, 1'b1, 32'hB0, 1'b1);
        do_lookup("t5_rr_000", 32'h000, 1'b0, 32'h0, 1'b0);
        // reset with a lookup in flight drops the response
        lookup_valid = 1'b1;
        lookup_pc    = 32'h040;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
        clear_inputs();
        check("t5_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("t5_rst_hit", {31'd0, resp_hit}, 32'd0);
        do_lookup("t5_rst_040", 32'h040, 1'b0, 32'h0, 1'b0);

        // T6: not-taken handling
        do_reset();
        do_upd(32'h700, 32'h780, 1'b1);
        do_lookup("t6_alloc", 32'h700, 1'b1, 32'h780, 1'b1);
`ifdef BTB_CONF_EN
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_ctr1", 32'h700, 1'b1, 32'h780, 1'b0);
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_ctr0", 32'h700, 1'b1, 32'h780, 1'b0);
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_ctr0s", 32'h700, 1'b1, 32'h780, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_upd(32'h700, 32'h790, 1'b1);
        end
        do_lookup("t6_ctr3", 32'h700, 1'b1, 32'h790, 1'b1);
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_ctr2", 32'h700, 1'b1, 32'h790, 1'b1);
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_ctr1b", 32'h700, 1'b1, 32'h790, 1'b0);
`else
        do_upd(32'h700, 32'h0, 1'b0);
        do_upd(32'h700, 32'h0, 1'b0);
        do_lookup("t6_nt_ign", 32'h700, 1'b1, 32'h780, 1'b1);
`endif
        do_upd(32'h704, 32'h7F0, 1'b0);
        do_lookup("t6_nt_miss", 32'h704, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
